// File: rtl/cpc_ram_pkg.sv
// Shared decode constants, FSM state codes and the quadrant page map.
// Latency: n/a (package).
// Backpressure: n/a (package).
package cpc_ram_pkg;

  // Committed mode values, as written in D2:D0 of a RAM-configuration OUT
  localparam logic [2:0] MODE_NONE  = 3'd0;  // no expansion mapping
  localparam logic [2:0] MODE_C3    = 3'd1;  // quadrant 3 -> page 3
  localparam logic [2:0] MODE_LIN   = 3'd2;  // all four quadrants, linear
  localparam logic [2:0] MODE_C3_LO = 3'd3;  // quadrant 3 -> page 3
  localparam logic [2:0] MODE_P4    = 3'd4;  // quadrant 1 -> page 0
  localparam logic [2:0] MODE_P5    = 3'd5;  // quadrant 1 -> page 1
  localparam logic [2:0] MODE_P6    = 3'd6;  // quadrant 1 -> page 2
  localparam logic [2:0] MODE_P7    = 3'd7;  // quadrant 1 -> page 3

  // Gate Array RAM-configuration port: A15 low, data tag D7:D6 = 11
  localparam logic       CFG_A15 = 1'b0;
  localparam logic [1:0] CFG_TAG = 2'b11;

  // Config port FSM states
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ARMED = 1'b1;

  typedef struct packed {
    logic       mapped;
    logic [1:0] page;
  } pmap_t;

  // Which SRAM page (if any) a Z80 quadrant lands in under a given mode
  function automatic pmap_t page_map(input logic [2:0] mode, input logic [1:0] q);
    pmap_t r;
    r = '0;
    case (mode)
      MODE_C3, MODE_C3_LO: begin
        r.mapped = (q == 2'd3);
        r.page   = 2'd3;
      end
      MODE_LIN: begin
        r.mapped = 1'b1;
        r.page   = q;
      end
      MODE_P4, MODE_P5, MODE_P6, MODE_P7: begin
        r.mapped = (q == 2'd1);
        r.page   = mode[1:0];
      end
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cpc_ram_cfg_port.sv
// Two-state capture/commit register for RAM-configuration writes.
// Latency: config commits on the first edge cfg_wr is sampled low after the OUT.
// Backpressure: none; every qualified write is taken, the last sample wins.
module cpc_ram_cfg_port
  import cpc_ram_pkg::*;
#(
  parameter int BLK_BITS = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_wr,
  input  logic [5:0]          d_lo,
  input  logic [2:0]          a_ext,
  output logic [2:0]          mode,
  output logic [BLK_BITS-1:0] blk
);

  logic [0:0]          state;
  logic [2:0]          pend_mode;
  logic [BLK_BITS-1:0] pend_blk;
  logic [5:0]          blk_full;
  logic                unused_blk;

  // Block number: D5:D3 low bits, extension bits from inverted A10:A8
  assign blk_full   = {~a_ext, d_lo[5:3]};
  assign unused_blk = ^blk_full;

  // Capture while the strobe is active, commit on the first inactive edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pend_mode <= '0;
      pend_blk  <= '0;
      mode      <= '0;
      blk       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cfg_wr) begin
            pend_mode <= d_lo[2:0];
            pend_blk  <= blk_full[BLK_BITS-1:0];
            state     <= ARMED;
          end
        end
        default: begin
          if (cfg_wr) begin
            pend_mode <= d_lo[2:0];
            pend_blk  <= blk_full[BLK_BITS-1:0];
          end else begin
            mode  <= pend_mode;
            blk   <= pend_blk;
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/cpc_ram_banker.sv
// CPC RAM expansion banker: config port decode plus SRAM address/strobe map.
// Latency: memory path is combinational from the bus and committed config.
// Backpressure: none; accesses never stall and READY is left alone.
module cpc_ram_banker
  import cpc_ram_pkg::*;
#(
  parameter int BLK_BITS = 3  // legal 3..6 (512K..4MB)
) (
  input  logic                CLK,
  input  logic                RESET_B,
  input  logic [7:0]          A,
  input  logic [7:0]          D,
  input  logic                MREQ_B,
  input  logic                IOREQ_B,
  input  logic                RD_B,
  input  logic                WR_B,
  input  logic                RFSH_B,
  input  logic                M1_B,
  output logic [BLK_BITS+1:0] HIADR,
  output logic                RAMCS_B,
  output logic                RAMOE_B,
  output logic                RAMWE_B,
  output logic                RAMDIS,
  output logic [2:0]          CFG_MODE
);

  localparam int HIADR_W = BLK_BITS + 2;

  logic                cfg_wr;
  logic [2:0]          mode;
  logic [BLK_BITS-1:0] blk;
  pmap_t               pm;
  logic                hit;
  logic                unused_a;

  assign unused_a = ^A[6:3];

  // Qualified OUT to the RAM-config port; M1 low means interrupt acknowledge
  always_comb begin
    cfg_wr = !IOREQ_B && !WR_B && M1_B && (A[7] == CFG_A15) && (D[7:6] == CFG_TAG);
  end

  cpc_ram_cfg_port #(.BLK_BITS(BLK_BITS)) u_cfg (
    .clk    (CLK),
    .rst_n  (RESET_B),
    .cfg_wr (cfg_wr),
    .d_lo   (D[5:0]),
    .a_ext  (A[2:0]),
    .mode   (mode),
    .blk    (blk)
  );

  // Map the current quadrant; refresh cycles never reach the SRAM
  always_comb begin
    pm  = page_map(mode, A[7:6]);
    hit = pm.mapped && !MREQ_B && RFSH_B;
  end

  // SRAM strobes and CPC RAM disable follow the hit directly
  always_comb begin
    RAMDIS   = hit;
    RAMCS_B  = !hit;
    RAMOE_B  = !(hit && !RD_B);
    RAMWE_B  = !(hit && !WR_B);
    HIADR    = hit ? HIADR_W'({blk, pm.page}) : '0;
    CFG_MODE = mode;
  end

endmodule

// File: tb/tb_cpc_ram_banker.sv
module tb_cpc_ram_banker;

  logic       CLK = 1'b0;
  logic       RESET_B;
  logic [7:0] A;
  logic [7:0] D;
  logic       MREQ_B, IOREQ_B, RD_B, WR_B, RFSH_B, M1_B;

  logic [4:0] HIADR;
  logic       RAMCS_B, RAMOE_B, RAMWE_B, RAMDIS;
  logic [2:0] CFG_MODE;

  logic [7:0] w_hiadr;
  logic       w_cs, w_oe, w_we, w_dis;
  logic [2:0] w_mode;

  int vecs = 0;
  int errs = 0;

  always #5 CLK = ~CLK;

  cpc_ram_banker #(.BLK_BITS(3)) dut (
    .CLK(CLK), .RESET_B(RESET_B), .A(A), .D(D),
    .MREQ_B(MREQ_B), .IOREQ_B(IOREQ_B), .RD_B(RD_B), .WR_B(WR_B),
    .RFSH_B(RFSH_B), .M1_B(M1_B),
    .HIADR(HIADR), .RAMCS_B(RAMCS_B), .RAMOE_B(RAMOE_B), .RAMWE_B(RAMWE_B),
    .RAMDIS(RAMDIS), .CFG_MODE(CFG_MODE)
  );

  cpc_ram_banker #(.BLK_BITS(6)) dut_w (
    .CLK(CLK), .RESET_B(RESET_B), .A(A), .D(D),
    .MREQ_B(MREQ_B), .IOREQ_B(IOREQ_B), .RD_B(RD_B), .WR_B(WR_B),
    .RFSH_B(RFSH_B), .M1_B(M1_B),
    .HIADR(w_hiadr), .RAMCS_B(w_cs), .RAMOE_B(w_oe), .RAMWE_B(w_we),
    .RAMDIS(w_dis), .CFG_MODE(w_mode)
  );

  // All bus tasks start and end just after a falling edge
  task automatic bus_idle();
    MREQ_B = 1'b1; IOREQ_B = 1'b1; RD_B = 1'b1; WR_B = 1'b1;
    RFSH_B = 1'b1; M1_B = 1'b1;
  endtask

  task automatic do_out(input logic [7:0] a, input logic [7:0] d);
    A = a; D = d; IOREQ_B = 1'b0; WR_B = 1'b0;
    @(posedge CLK); @(negedge CLK);
    @(posedge CLK); @(negedge CLK);
    IOREQ_B = 1'b1; WR_B = 1'b1;
    @(posedge CLK); @(negedge CLK);
  endtask

  task automatic mem(input logic [7:0] a, input logic rd, input logic wr, input logic rfsh);
    bus_idle();
    A = a; MREQ_B = 1'b0; RD_B = !rd; WR_B = !wr; RFSH_B = !rfsh;
    #1;
  endtask

  task automatic test_reset();
    bus_idle(); A = 8'h40; D = 8'h00; RESET_B = 1'b0;
    @(negedge CLK); @(negedge CLK);
    vecs++; if (RAMCS_B !== 1'b1) begin errs++; $display("FAIL rst_cs got %b want 1", RAMCS_B); end
    vecs++; if (RAMOE_B !== 1'b1) begin errs++; $display("FAIL rst_oe got %b want 1", RAMOE_B); end
    vecs++; if (RAMWE_B !== 1'b1) begin errs++; $display("FAIL rst_we got %b want 1", RAMWE_B); end
    vecs++; if (RAMDIS !== 1'b0) begin errs++; $display("FAIL rst_dis got %b want 0", RAMDIS); end
    vecs++; if (HIADR !== 5'd0) begin errs++; $display("FAIL rst_hiadr got %b want 00000", HIADR); end
    vecs++; if (CFG_MODE !== 3'd0) begin errs++; $display("FAIL rst_mode got %0d want 0", CFG_MODE); end
    RESET_B = 1'b1;
    @(negedge CLK);
    mem(8'h40, 1'b1, 1'b0, 1'b0);
    vecs++; if (RAMCS_B !== 1'b1) begin errs++; $display("FAIL rst_rd4000_cs got %b want 1", RAMCS_B); end
    bus_idle();
  endtask

  task automatic test_mode4();
    do_out(8'h7F, 8'hC4);
    vecs++; if (CFG_MODE !== 3'd4) begin errs++; $display("FAIL m4_mode got %0d want 4", CFG_MODE); end
    mem(8'h41, 1'b1, 1'b0, 1'b0);
    vecs++; if (RAMCS_B !== 1'b0) begin errs++; $display("FAIL m4_cs got %b want 0", RAMCS_B); end
    vecs++; if (RAMOE_B !== 1'b0) begin errs++; $display("FAIL m4_oe got %b want 0", RAMOE_B); end
    vecs++; if (RAMWE_B !== 1'b1) begin errs++; $display("FAIL m4_we got %b want 1", RAMWE_B); end
    vecs++; if (RAMDIS !== 1'b1) begin errs++; $display("FAIL m4_dis got %b want 1", RAMDIS); end
    vecs++; if (HIADR !== 5'b000_00) begin errs++; $display("FAIL m4_hiadr got %b want 00000", HIADR); end
    mem(8'h81, 1'b1, 1'b0, 1'b0);
    vecs++; if (RAMCS_B !== 1'b1) begin errs++; $display("FAIL m4_8123_cs got %b want 1", RAMCS_B); end
    vecs++; if (RAMDIS !== 1'b0) begin errs++; $display("FAIL m4_8123_dis got %b want 0", RAMDIS); end
    vecs++; if (HIADR !== 5'd0) begin errs++; $display("FAIL m4_8123_hiadr got %b want 00000", HIADR); end
    bus_idle(); @(negedge CLK);
  endtask

  task automatic test_latency();
    // mode 4 active; OUT &C2 must not take effect until the strobe drops
    A = 8'h7F; D = 8'hC2; IOREQ_B = 1'b0; WR_B = 1'b0;
    @(posedge CLK); @(negedge CLK);
    vecs++; if (CFG_MODE !== 3'd4) begin errs++; $display("FAIL lat_armed got %0d want 4", CFG_MODE); end
    IOREQ_B = 1'b1; WR_B = 1'b1;
    @(posedge CLK); @(negedge CLK);
    vecs++; if (CFG_MODE !== 3'd2) begin errs++; $display("FAIL lat_commit got %0d want 2", CFG_MODE); end
  endtask

  task automatic test_mode2();
    logic [7:0] qa [4] = '{8'h00, 8'h40, 8'h80, 8'hC0};
    logic [4:0] exp [4] = '{5'b000_00, 5'b000_01, 5'b000_10, 5'b000_11};
    do_out(8'h7F, 8'hC2);
    for (int i = 0; i < 4; i++) begin
      mem(qa[i], 1'b1, 1'b0, 1'b0);
      vecs++; if (HIADR !== exp[i] || RAMCS_B !== 1'b0) begin
        errs++; $display("FAIL m2_q%0d got hiadr=%b cs=%b want hiadr=%b cs=0", i, HIADR, RAMCS_B, exp[i]);
      end
    end
    bus_idle(); @(negedge CLK);
    do_out(8'h7F, 8'hCA);
    mem(8'hC0, 1'b1, 1'b0, 1'b0);
    vecs++; if (HIADR !== 5'b001_11) begin errs++; $display("FAIL m2_blk1 got %b want 00111", HIADR); end
    bus_idle(); @(negedge CLK);
  endtask

  task automatic test_wide();
    do_out(8'h7A, 8'hFF);
    mem(8'h40, 1'b0, 1'b1, 1'b0);
    vecs++; if (w_hiadr !== 8'b101111_11) begin errs++; $display("FAIL wide_hiadr got %b want 10111111", w_hiadr); end
    vecs++; if (w_we !== 1'b0) begin errs++; $display("FAIL wide_we_act got %b want 0", w_we); end
    vecs++; if (HIADR !== 5'b111_11) begin errs++; $display("FAIL narrow_hiadr got %b want 11111", HIADR); end
    WR_B = 1'b1; #1;
    vecs++; if (w_we !== 1'b1) begin errs++; $display("FAIL wide_we_idle got %b want 1", w_we); end
    vecs++; if (w_cs !== 1'b0) begin errs++; $display("FAIL wide_cs got %b want 0", w_cs); end
    bus_idle(); @(negedge CLK);
  endtask

  task automatic test_ignored();
    do_out(8'h7F, 8'hC0);
    do_out(8'h7F, 8'h54);
    vecs++; if (CFG_MODE !== 3'd0) begin errs++; $display("FAIL palette_mode got %0d want 0", CFG_MODE); end
    // interrupt acknowledge with a RAM-config looking data byte
    A = 8'h7F; D = 8'hC4; IOREQ_B = 1'b0; M1_B = 1'b0; WR_B = 1'b0;
    repeat (2) begin @(posedge CLK); @(negedge CLK); end
    bus_idle();
    repeat (2) begin @(posedge CLK); @(negedge CLK); end
    vecs++; if (CFG_MODE !== 3'd0) begin errs++; $display("FAIL inta_mode got %0d want 0", CFG_MODE); end
    do_out(8'hFF, 8'hC4);
    vecs++; if (CFG_MODE !== 3'd0) begin errs++; $display("FAIL a15_mode got %0d want 0", CFG_MODE); end
    mem(8'h40, 1'b1, 1'b0, 1'b0);
    vecs++; if (RAMCS_B !== 1'b1) begin errs++; $display("FAIL ign_cs got %b want 1", RAMCS_B); end
    bus_idle(); @(negedge CLK);
  endtask

  task automatic test_reset_armed();
    do_out(8'h7F, 8'hC4);
    A = 8'h7F; D = 8'hC7; IOREQ_B = 1'b0; WR_B = 1'b0;
    @(posedge CLK); @(negedge CLK);
    RESET_B = 1'b0; #1;
    vecs++; if (CFG_MODE !== 3'd0) begin errs++; $display("FAIL rarm_in_rst got %0d want 0", CFG_MODE); end
    bus_idle();
    @(negedge CLK);
    RESET_B = 1'b1;
    repeat (2) begin @(posedge CLK); @(negedge CLK); end
    vecs++; if (CFG_MODE !== 3'd0) begin errs++; $display("FAIL rarm_after got %0d want 0", CFG_MODE); end
    mem(8'h40, 1'b1, 1'b0, 1'b0);
    vecs++; if (RAMCS_B !== 1'b1) begin errs++; $display("FAIL rarm_cs got %b want 1", RAMCS_B); end
    bus_idle(); @(negedge CLK);
  endtask

  task automatic test_refresh();
    do_out(8'h7F, 8'hC4);
    mem(8'h40, 1'b0, 1'b0, 1'b1);
    vecs++; if (RAMCS_B !== 1'b1) begin errs++; $display("FAIL rfsh_cs got %b want 1", RAMCS_B); end
    vecs++; if (RAMDIS !== 1'b0) begin errs++; $display("FAIL rfsh_dis got %b want 0", RAMDIS); end
    vecs++; if (HIADR !== 5'd0) begin errs++; $display("FAIL rfsh_hiadr got %b want 00000", HIADR); end
    bus_idle(); @(negedge CLK);
  endtask

  task automatic test_held();
    logic [7:0] seq [3] = '{8'hC1, 8'hC5, 8'hCE};
    A = 8'h7F; IOREQ_B = 1'b0; WR_B = 1'b0;
    for (int i = 0; i < 3; i++) begin
      D = seq[i];
      @(posedge CLK); @(negedge CLK);
      vecs++; if (CFG_MODE !== 3'd4) begin errs++; $display("FAIL held_edge%0d got %0d want 4", i, CFG_MODE); end
    end
    IOREQ_B = 1'b1; WR_B = 1'b1;
    @(posedge CLK); @(negedge CLK);
    vecs++; if (CFG_MODE !== 3'd6) begin errs++; $display("FAIL held_mode got %0d want 6", CFG_MODE); end
    mem(8'h40, 1'b1, 1'b0, 1'b0);
    vecs++; if (HIADR !== 5'b001_10) begin errs++; $display("FAIL held_hiadr got %b want 00110", HIADR); end
    bus_idle(); @(negedge CLK);
  endtask

  task automatic test_back_to_back();
    do_out(8'h7F, 8'hC2);
    vecs++; if (CFG_MODE !== 3'd2) begin errs++; $display("FAIL b2b_first got %0d want 2", CFG_MODE); end
    do_out(8'h7F, 8'hC5);
    vecs++; if (CFG_MODE !== 3'd5) begin errs++; $display("FAIL b2b_second got %0d want 5", CFG_MODE); end
    mem(8'h40, 1'b1, 1'b0, 1'b0);
    vecs++; if (HIADR !== 5'b000_01) begin errs++; $display("FAIL b2b_hiadr got %b want 00001", HIADR); end
    bus_idle(); @(negedge CLK);
  endtask

  initial begin
    RESET_B = 1'b0; A = 8'h00; D = 8'h00;
    bus_idle();
    @(negedge CLK);
    test_reset();
    test_mode4();
    test_latency();
    test_mode2();
    test_wide();
    test_ignored();
    test_reset_armed();
    test_refresh();
    test_held();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
